// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem_pkg
// Description : Shared definitions for the byte-serial data memory unit:
//               load/store funct3 codes, FSM state encoding, access-size
//               decode, funct3 legality and load-result extension.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  // RISC-V load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // RISC-V store funct3 codes
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_e;

  // Access size in bytes; the low two funct3 bits encode it for loads and
  // stores alike (LBU/LHU share the size of LB/LH).
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3 & 3'b011)
      F3_SB:   return 3'd1;
      F3_SH:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    if (we) return (f3 <= F3_SW);
    else    return !((f3 == 3'd3) || (f3 > F3_LHU));
  endfunction

  // v holds the loaded bytes right-aligned
  function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                              input logic [31:0] v);
    case (f3)
      F3_LB:   return {{24{v[7]}}, v[7:0]};
      F3_LH:   return {{16{v[15]}}, v[15:0]};
      F3_LBU:  return {24'd0, v[7:0]};
      F3_LHU:  return {16'd0, v[15:0]};
      F3_LW:   return v;
      default: return v;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : riscv_byte_ram
// Description : MEM_BYTES x 8 single-port RAM, combinational read and
//               synchronous write. Contents are not reset.
// Ports       : clk      - clock
//               we_i     - write enable (write at rising edge)
//               addr_i   - byte address (read and write)
//               wdata_i  - write byte
//               rdata_o  - read byte at addr_i (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_byte_ram #(
  parameter int MEM_BYTES = 128,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule
`default_nettype wire

// File: rtl/riscv_mem.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mem
// Description : Byte-serial data memory and GPIO unit. Accepts one load or
//               store at a time, moves one byte per cycle through a byte RAM
//               (big-endian), returns extended load data and drives a
//               memory-mapped GPIO register. Illegal accesses report rsp_err.
// Ports       : clk, rst              - clock, async active-high reset
//               req_valid/req_ready   - request handshake
//               req_we, req_funct3    - store flag and RISC-V funct3
//               req_addr, req_wdata   - byte address and store data
//               rsp_valid             - one-cycle completion pulse
//               rsp_rdata, rsp_err    - load result / error flag
//               gpio                  - GPIO register
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mem
  import riscv_mem_pkg::*;
#(
  parameter int          MEM_BYTES = 128,
  parameter logic [31:0] GPIO_ADDR = 32'h0000_0100,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [GPIO_W-1:0] gpio
);

  localparam int AW = $clog2(MEM_BYTES);

  mem_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic              is_gpio_q, is_gpio_d;
  logic [AW-1:0]     base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        k_q, k_d;
  logic [23:0]       acc_q, acc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;

  // ---------------------------------------------------------------- decode
  logic [2:0]  w_size;
  logic        w_is_gpio;
  logic        w_misalign;
  logic [32:0] w_last;
  logic        w_oob;
  logic        w_err;

  assign w_size     = size_bytes(req_funct3);
  assign w_is_gpio  = (req_addr == GPIO_ADDR);
  assign w_misalign = ((w_size == 3'd2) && req_addr[0]) ||
                      ((w_size == 3'd4) && (req_addr[1:0] != 2'b00));
  // 33-bit so an access near 2^32 cannot wrap back into range
  assign w_last     = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
  assign w_oob      = !w_is_gpio && (w_last >= 33'(MEM_BYTES));
  assign w_err      = !f3_valid(req_we, req_funct3) || w_misalign || w_oob;

  // ---------------------------------------------------------- RAM datapath
  logic [2:0]    w_size_q;
  logic [1:0]    w_byte_idx;
  logic          w_last_byte;
  logic [AW-1:0] w_ram_addr;
  logic          w_ram_we;
  logic [7:0]    w_ram_wdata;
  logic [7:0]    w_ram_rdata;
  logic [31:0]   w_acc_next;

  assign w_size_q    = size_bytes(f3_q);
  // Big-endian: byte k of an N-byte access is data byte N-1-k
  assign w_byte_idx  = 2'(w_size_q - 3'd1 - k_q);
  assign w_last_byte = (k_q == (w_size_q - 3'd1));
  assign w_ram_addr  = base_q + AW'(k_q);
  assign w_ram_we    = (state_q == ST_ACCESS) && we_q && !is_gpio_q;
  assign w_ram_wdata = wdata_q[{w_byte_idx, 3'b000} +: 8];
  assign w_acc_next  = {acc_q, w_ram_rdata};

  riscv_byte_ram #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_addr),
    .wdata_i (w_ram_wdata),
    .rdata_o (w_ram_rdata)
  );

  // ---------------------------------------------------------- next state
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    is_gpio_d   = is_gpio_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    acc_d       = acc_q;
    gpio_d      = gpio_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          f3_d      = req_funct3;
          is_gpio_d = w_is_gpio;
          base_d    = req_addr[AW-1:0];
          wdata_d   = req_wdata;
          k_d       = 3'd0;
          acc_d     = 24'd0;
          if (w_err) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        if (is_gpio_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (we_q) begin
            gpio_d = wdata_q[GPIO_W-1:0];
          end else begin
            rsp_rdata_d = load_extend(f3_q, 32'(gpio_q));
          end
        end else begin
          k_d = k_q + 3'd1;
          if (!we_q) begin
            acc_d = w_acc_next[23:0];
          end
          if (w_last_byte) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            if (!we_q) begin
              rsp_rdata_d = load_extend(f3_q, w_acc_next);
            end
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        k_d     = 3'd0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      is_gpio_q   <= 1'b0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      k_q         <= 3'd0;
      acc_q       <= 24'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      gpio_q      <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      is_gpio_q   <= is_gpio_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      gpio_q      <= gpio_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign gpio      = gpio_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_riscv_mem
// Description : Self-checking bench for riscv_mem. A transaction-level model
//               predicts acceptance, response timing, load data, RAM and GPIO
//               contents; a per-cycle compare process checks the DUT against
//               it, and directed requests pin literal results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_mem;

  localparam int          MEM_BYTES = 128;
  localparam logic [31:0] GPIO_ADDR = 32'h0000_0100;
  localparam int          GPIO_W    = 8;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              req_ready;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [GPIO_W-1:0] gpio;

  riscv_mem #(
    .MEM_BYTES (MEM_BYTES),
    .GPIO_ADDR (GPIO_ADDR),
    .GPIO_W    (GPIO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .gpio       (gpio)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    int         at;
    bit         to_gpio;
    int         addr;
    logic [7:0] val;
  } wr_t;

  logic [7:0] m_ram [MEM_BYTES];
  logic [7:0] m_gpio   = 8'd0;
  int         cyc      = 0;
  int         ready_at = 0;
  int         n_acc    = 0;
  int         n_rsp    = 0;
  rsp_t       exp_q[$];
  wr_t        wr_q[$];

  task automatic model_accept(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int          n;
    int          d;
    int          s;
    bit          bad;
    longint      last;
    logic [31:0] v;
    logic [31:0] sh;
    rsp_t        r;
    wr_t         w;
    n    = 1 << (f3 % 4);
    bad  = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 >= 3'd6));
    if ((addr % n) != 0) bad = 1;
    last = longint'({32'd0, addr}) + n - 1;
    if ((addr != GPIO_ADDR) && (last >= MEM_BYTES)) bad = 1;
    v       = 32'd0;
    r.rdata = 32'd0;
    r.err   = bad;
    d       = 0;
    if (!bad) begin
      if (addr == GPIO_ADDR) begin
        d = 1;
        if (we) begin
          w.at = cyc + 1; w.to_gpio = 1; w.addr = 0; w.val = wdata[7:0];
          wr_q.push_back(w);
        end else begin
          v = {24'd0, m_gpio};
        end
      end else begin
        d = n;
        for (int i = 0; i < n; i++) begin
          if (we) begin
            sh = wdata >> (8 * (n - 1 - i));
            w.at = cyc + 1 + i; w.to_gpio = 0; w.addr = int'(addr) + i; w.val = sh[7:0];
            wr_q.push_back(w);
          end else begin
            v = (v << 8) | {24'd0, m_ram[int'(addr) + i]};
          end
        end
      end
      if (!we) begin
        case (f3)
          LB:  begin s = int'(v & 32'hFF);   if (s >= 128)   s -= 256;   r.rdata = s; end
          LH:  begin s = int'(v & 32'hFFFF); if (s >= 32768) s -= 65536; r.rdata = s; end
          LBU: r.rdata = v & 32'hFF;
          LHU: r.rdata = v & 32'hFFFF;
          default: r.rdata = v;
        endcase
      end
    end
    r.due    = cyc + d;
    ready_at = cyc + d + 2;
    exp_q.push_back(r);
    n_acc++;
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) m_ram[i] = 8'd0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        wr_q.delete();
        m_gpio   = 8'd0;
        ready_at = 0;
      end else begin
        cyc++;
        while (wr_q.size() > 0 && wr_q[0].at == cyc) begin
          if (wr_q[0].to_gpio) m_gpio = wr_q[0].val;
          else                 m_ram[wr_q[0].addr] = wr_q[0].val;
          void'(wr_q.pop_front());
        end
        if (req_valid && cyc >= ready_at)
          model_accept(req_we, req_funct3, req_addr, req_wdata);
      end
    end
  end

  // ------------------------------------------------------ per-cycle compare
  initial begin
    bit exp_v;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("req_ready", 32'(req_ready), 32'(cyc + 1 >= ready_at));
      chk("gpio", 32'(gpio), 32'(m_gpio));
      if (exp_v) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_rdata idle", rsp_rdata, 32'd0);
        chk("rsp_err idle", 32'(rsp_err), 32'd0);
      end
      if (rsp_valid) n_rsp++;
    end
  end

  // --------------------------------------------------------------- driver
  task automatic do_req(input string nm, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " rdata"}, rsp_rdata, exp_rdata);
    chk({nm, " err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  task automatic check_ram(input string nm);
    for (int i = 0; i < MEM_BYTES; i++)
      chk(nm, {24'd0, dut.u_ram.mem[i]}, {24'd0, m_ram[i]});
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
  } hv_t;

  hv_t tbl [10];

  initial begin
    int acc0;
    int rsp0;
    tbl[0] = '{1'b1, SW, 32'd16};    tbl[1] = '{1'b0, LW, 32'd16};
    tbl[2] = '{1'b0, LBU, 32'd17};   tbl[3] = '{1'b1, SB, 32'd21};
    tbl[4] = '{1'b0, LB, 32'd21};    tbl[5] = '{1'b0, LH, 32'd6};
    tbl[6] = '{1'b0, 3'd3, 32'd0};   tbl[7] = '{1'b1, SW, GPIO_ADDR};
    tbl[8] = '{1'b0, LHU, GPIO_ADDR}; tbl[9] = '{1'b1, SH, 32'd127};

    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset gpio", 32'(gpio), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known RAM contents everywhere
    for (int a = 0; a < MEM_BYTES; a += 4)
      do_req("init SW", 1'b1, SW, a, 32'd0, 32'd0, 1'b0, 5);
    check_ram("init ram");

    do_req("SW 8", 1'b1, SW, 32'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, 5);
    do_req("LW 8", 1'b0, LW, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b0, 5);
    chk("ram[8]",  32'(dut.u_ram.mem[8]),  32'hDE);
    chk("ram[9]",  32'(dut.u_ram.mem[9]),  32'hAD);
    chk("ram[10]", 32'(dut.u_ram.mem[10]), 32'hBE);
    chk("ram[11]", 32'(dut.u_ram.mem[11]), 32'hEF);

    do_req("SB 3",  1'b1, SB,  32'd3, 32'h0000_0080, 32'd0,         1'b0, 2);
    do_req("LB 3",  1'b0, LB,  32'd3, 32'd0,         32'hFFFF_FF80, 1'b0, 2);
    do_req("LBU 3", 1'b0, LBU, 32'd3, 32'd0,         32'h0000_0080, 1'b0, 2);
    do_req("SH 4",  1'b1, SH,  32'd4, 32'h0000_8001, 32'd0,         1'b0, 3);
    do_req("LH 4",  1'b0, LH,  32'd4, 32'd0,         32'hFFFF_8001, 1'b0, 3);
    do_req("LHU 4", 1'b0, LHU, 32'd4, 32'd0,         32'h0000_8001, 1'b0, 3);

    do_req("LW 6 misaligned", 1'b0, LW,   32'd6,   32'd0, 32'd0, 1'b1, 1);
    do_req("LH 127 misalign", 1'b0, LH,   32'd127, 32'd0, 32'd0, 1'b1, 1);
    do_req("SW 128 range",    1'b1, SW,   32'd128, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    do_req("load funct3=3",   1'b0, 3'd3, 32'd0,   32'd0, 32'd0, 1'b1, 1);
    do_req("store funct3=3",  1'b1, 3'd3, 32'd0,   32'h1234_5678, 32'd0, 1'b1, 1);
    do_req("SW wrap addr",    1'b1, SW,   32'hFFFF_FFFC, 32'h1, 32'd0, 1'b1, 1);
    do_req("LB 127 edge",     1'b0, LB,   32'd127, 32'd0, 32'd0, 1'b0, 2);
    do_req("LW 124 edge",     1'b0, LW,   32'd124, 32'd0, 32'd0, 1'b0, 5);
    check_ram("ram after errors");

    do_req("SW gpio", 1'b1, SW, GPIO_ADDR, 32'h0000_00A5, 32'd0, 1'b0, 2);
    chk("gpio A5", 32'(gpio), 32'hA5);
    do_req("LB gpio", 1'b0, LB, GPIO_ADDR, 32'd0, 32'hFFFF_FFA5, 1'b0, 2);

    // req_valid held high with fields changing every cycle
    acc0 = n_acc;
    rsp0 = n_rsp;
    for (int i = 0; i < 50; i++) begin
      req_valid  = 1'b1;
      req_we     = tbl[i % 10].we;
      req_funct3 = tbl[i % 10].f3;
      req_addr   = tbl[i % 10].addr;
      req_wdata  = 32'h8182_8300 + i;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("hold rsp count", 32'(n_rsp - rsp0), 32'(n_acc - acc0));
    check_ram("ram after hold");

    // Known state for the abort check
    do_req("SW 0 clr", 1'b1, SW, 32'd0, 32'h0000_0080, 32'd0, 1'b0, 5);
    do_req("SW gpio 2", 1'b1, SW, GPIO_ADDR, 32'h0000_003C, 32'd0, 1'b0, 2);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'd0;
    req_wdata = 32'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort gpio", 32'(gpio), 32'd0);
    chk("abort ram[0]", 32'(dut.u_ram.mem[0]), 32'h11);
    chk("abort ram[1]", 32'(dut.u_ram.mem[1]), 32'h00);
    chk("abort ram[2]", 32'(dut.u_ram.mem[2]), 32'h00);
    chk("abort ram[3]", 32'(dut.u_ram.mem[3]), 32'h80);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_ram("ram after abort");
    do_req("LW 0 after abort", 1'b0, LW, 32'd0, 32'd0, 32'h1100_0080, 1'b0, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
